dataframe_capture_ctrl: RTL

DATAFRAME_CAPTURE_CTRL -- requirements
Module: dataframe_capture_ctrl

---
 rtl/dataframe_capture_pkg.sv | 20 ++
 rtl/dataframe_trig_match.sv | 17 +
 rtl/dataframe_capture_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dataframe_capture_pkg.sv
// Shared definitions for the uplink dataframe capture controller:
// FSM state encoding, uplink frame width and error-bit positions.
package dataframe_capture_pkg;

    // Width of one lpGBT uplink user-data frame.
    localparam int FRAME_W = 234;

    // Bit positions inside err_o.
    localparam int ERR_LINK_BIT = 0;
    localparam int ERR_TMO_BIT  = 1;

    // Capture FSM states; encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/dataframe_trig_match.sv
// Masked pattern comparator: hit when (data & mask) == (pat & mask).
// Purely combinational; a zero mask always matches.
module dataframe_trig_match #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic [W-1:0] pat,
    input  logic [W-1:0] mask,
    output logic         hit
);

    // Compare only the bits selected by the mask.
    always_comb begin
        hit = ((data & mask) == (pat & mask));
    end

endmodule

// File: rtl/dataframe_capture_ctrl.sv
// Uplink dataframe capture controller.
// Arms on request, waits for the first frame (or a masked pattern match),
// then writes n_frames consecutive uplink frames into a frame buffer at
// addresses 0..n_frames-1 with a fixed one-cycle latency.
//
// Frame strobe semantics: frame_vld_i is a one-cycle strobe with no
// back-pressure; frame_i is only meaningful in a cycle with frame_vld_i=1,
// and every accepted strobe yields exactly one buf_we_o pulse one cycle later.
//
// Optional build macro CAPTURE_TIMEOUT_EN adds an arm timeout (err_o[1]);
// without it tmo_i is ignored and err_o[1] is always 0.
module dataframe_capture_ctrl
    import dataframe_capture_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int TRIG_W = 32,
    parameter int TMO_W  = 24
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic               uplinkrdy_i,
    input  logic               frame_vld_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic [ADDR_W:0]    n_frames_i,
    input  logic               trig_en_i,
    input  logic [TRIG_W-1:0]  trig_pat_i,
    input  logic [TRIG_W-1:0]  trig_mask_i,
    input  logic [TMO_W-1:0]   tmo_i,
    input  logic               done_ack_i,
    output logic               buf_we_o,
    output logic [ADDR_W-1:0]  buf_addr_o,
    output logic [FRAME_W-1:0] buf_wdata_o,
    output logic [1:0]         state_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         err_o,
    output logic [ADDR_W:0]    count_o
);

    cap_state_t          state_q;
    cap_state_t          state_nxt;

    // Capture settings latched on arm; live inputs are ignored while busy.
    logic [ADDR_W:0]     n_q;
    logic                trig_en_q;
    logic [TRIG_W-1:0]   pat_q;
    logic [TRIG_W-1:0]   mask_q;

    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_inc;
    logic                buf_we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [FRAME_W-1:0]  wdata_q;
    logic                err_link_q;
    logic                err_tmo;

    logic                trig_hit;
    logic                n_ok;
    logic                arm_ok;
    logic                active;
    logic                link_loss;
    logic                wr_fire;
    logic                last_wr;
    logic                tmo_fire;

    dataframe_trig_match #(
        .W (TRIG_W)
    ) u_trig_match (
        .data (frame_i[TRIG_W-1:0]),
        .pat  (pat_q),
        .mask (mask_q),
        .hit  (trig_hit)
    );

    // Event decode: arm acceptance, link loss, frame writes. Abort beats
    // everything, link loss beats a coincident frame.
    always_comb begin
        n_ok      = (n_frames_i != '0) &&
                    (!n_frames_i[ADDR_W] || (n_frames_i[ADDR_W-1:0] == '0));
        arm_ok    = (state_q == ST_IDLE) && arm_i && uplinkrdy_i && n_ok;
        active    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
        link_loss = active && !abort_i && !uplinkrdy_i;
        wr_fire   = active && !abort_i && uplinkrdy_i && frame_vld_i &&
                    ((state_q == ST_CAPTURE) || !trig_en_q || trig_hit);
        count_inc = count_q + (ADDR_W + 1)'(1);
        last_wr   = (count_inc == n_q);
    end

`ifdef CAPTURE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_tmo_q;

    // Timeout fires on the edge where the ARMED cycle count reaches tmo.
    always_comb begin
        tmo_fire = (state_q == ST_ARMED) && !abort_i && uplinkrdy_i && !wr_fire &&
                   (tmo_q != '0) && ((tmo_cnt_q + TMO_W'(1)) == tmo_q);
        err_tmo  = err_tmo_q;
    end

    // Arm timeout counter: cleared on arm, counts every cycle spent in ARMED.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tmo_q     <= '0;
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            if (arm_ok) begin
                tmo_q     <= tmo_i;
                tmo_cnt_q <= '0;
                err_tmo_q <= 1'b0;
            end else if (state_q == ST_ARMED) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            if (tmo_fire) begin
                err_tmo_q <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;

    // No timeout hardware: the timeout input has no effect.
    always_comb begin
        tmo_fire   = 1'b0;
        err_tmo    = 1'b0;
        unused_tmo = ^tmo_i;
    end
`endif

    // FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state logic; DONE is entered on the edge of the final write.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_ok) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (link_loss || tmo_fire) begin
                    state_nxt = ST_DONE;
                end else if (wr_fire) begin
                    state_nxt = last_wr ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (done_ack_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM and status outputs.
    always_comb begin
        state_o             = state_q;
        busy_o              = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
        done_o              = (state_q == ST_DONE);
        err_o               = '0;
        err_o[ERR_LINK_BIT] = err_link_q;
        err_o[ERR_TMO_BIT]  = err_tmo;
        count_o             = count_q;
        buf_we_o            = buf_we_q;
        buf_addr_o          = addr_q;
        buf_wdata_o         = wdata_q;
    end

    // Datapath: latch settings on arm, register buffer writes, track count and link error.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            n_q        <= '0;
            trig_en_q  <= 1'b0;
            pat_q      <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            buf_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_link_q <= 1'b0;
        end else begin
            buf_we_q <= wr_fire;
            if (wr_fire) begin
                addr_q  <= count_q[ADDR_W-1:0];
                wdata_q <= frame_i;
                count_q <= count_inc;
            end
            if (arm_ok) begin
                n_q        <= n_frames_i;
                trig_en_q  <= trig_en_i;
                pat_q      <= trig_pat_i;
                mask_q     <= trig_mask_i;
                count_q    <= '0;
                err_link_q <= 1'b0;
            end
            if (link_loss) begin
                err_link_q <= 1'b1;
            end
        end
    end

endmodule
